// File: rtl/vid_mode_ctrl.sv
// Resolution-change sequencer for the pixel timing generator: waits for vsync,
// holds the timing generator in reset while `res` switches, then mutes video for a few frames.
module vid_mode_ctrl #(
    parameter logic [1:0]  DEFAULT_RES = 2'd0,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned MUTE_FRAMES = 2,
    parameter int unsigned VS_TIMEOUT  = 3000000
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic       req_valid,
    input  logic [1:0] req_res,
    output logic       req_ready,
    input  logic       vsync,
    output logic [1:0] res_out,
    output logic       tim_rst,
    output logic       blank,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned VS_CNT_W   = 22;
    localparam int unsigned RST_CNT_W  = 8;
    localparam int unsigned MUTE_CNT_W = 4;

    localparam logic [VS_CNT_W-1:0]   VS_LAST   = VS_CNT_W'(VS_TIMEOUT - 1);
    localparam logic [RST_CNT_W-1:0]  RST_LAST  = RST_CNT_W'(RST_CYCLES - 1);
    localparam logic [MUTE_CNT_W-1:0] MUTE_LAST =
        MUTE_CNT_W'((MUTE_FRAMES == 0) ? 0 : MUTE_FRAMES - 1);
    localparam logic [1:0]            RES_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_VS  = 2'd1,
        ST_HOLD_RST = 2'd2,
        ST_MUTE     = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_vs_q;
    logic [1:0]            r_res;
    logic [1:0]            w_res_nxt;
    logic [1:0]            r_tgt;
    logic [1:0]            w_tgt_nxt;
    logic                  r_tim_rst;
    logic                  w_tim_rst_nxt;
    logic                  r_blank;
    logic                  w_blank_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic [VS_CNT_W-1:0]   r_vs_cnt;
    logic [VS_CNT_W-1:0]   w_vs_cnt_nxt;
    logic [RST_CNT_W-1:0]  r_rst_cnt;
    logic [RST_CNT_W-1:0]  w_rst_cnt_nxt;
    logic [MUTE_CNT_W-1:0] r_mute_cnt;
    logic [MUTE_CNT_W-1:0] w_mute_cnt_nxt;

    logic w_idle;
    logic w_xfer;
    logic w_vs_fall;

    // Start of the (active-low) sync pulse, which lies inside vertical blanking.
    assign w_vs_fall = r_vs_q & ~vsync;
    assign w_idle    = (r_state == ST_IDLE);
    assign w_xfer    = req_valid & w_idle;

    assign req_ready = w_idle;
    assign busy      = ~w_idle;
    assign res_out   = r_res;
    assign tim_rst   = r_tim_rst;
    assign blank     = r_blank;
    assign done      = r_done;
    assign err       = r_err;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_state    <= ST_IDLE;
            r_vs_q     <= 1'b1;
            r_res      <= DEFAULT_RES;
            r_tgt      <= DEFAULT_RES;
            r_tim_rst  <= 1'b0;
            r_blank    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_vs_cnt   <= '0;
            r_rst_cnt  <= '0;
            r_mute_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_vs_q     <= vsync;
            r_res      <= w_res_nxt;
            r_tgt      <= w_tgt_nxt;
            r_tim_rst  <= w_tim_rst_nxt;
            r_blank    <= w_blank_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_vs_cnt   <= w_vs_cnt_nxt;
            r_rst_cnt  <= w_rst_cnt_nxt;
            r_mute_cnt <= w_mute_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_res_nxt      = r_res;
        w_tgt_nxt      = r_tgt;
        w_tim_rst_nxt  = r_tim_rst;
        w_blank_nxt    = r_blank;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_vs_cnt_nxt   = r_vs_cnt;
        w_rst_cnt_nxt  = r_rst_cnt;
        w_mute_cnt_nxt = r_mute_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (req_res == RES_ILLEGAL) begin
                        w_err_nxt = 1'b1;
                    end else if (req_res == r_res) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_tgt_nxt    = req_res;
                        w_vs_cnt_nxt = '0;
                        w_state_nxt  = ST_WAIT_VS;
                    end
                end
            end

            // Switch on the next sync start, or force it if vsync never shows up.
            ST_WAIT_VS: begin
                if (w_vs_fall || (r_vs_cnt == VS_LAST)) begin
                    w_res_nxt     = r_tgt;
                    w_tim_rst_nxt = 1'b1;
                    w_blank_nxt   = 1'b1;
                    w_vs_cnt_nxt  = '0;
                    w_rst_cnt_nxt = '0;
                    w_state_nxt   = ST_HOLD_RST;
                end else begin
                    w_vs_cnt_nxt = r_vs_cnt + VS_CNT_W'(1);
                end
            end

            ST_HOLD_RST: begin
                if (r_rst_cnt == RST_LAST) begin
                    w_tim_rst_nxt = 1'b0;
                    w_rst_cnt_nxt = '0;
                    if (MUTE_FRAMES == 0) begin
                        w_blank_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_mute_cnt_nxt = '0;
                        w_state_nxt    = ST_MUTE;
                    end
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + RST_CNT_W'(1);
                end
            end

            // Sync starts seen only once the timing generator runs again are counted.
            ST_MUTE: begin
                if (w_vs_fall) begin
                    if (r_mute_cnt == MUTE_LAST) begin
                        w_mute_cnt_nxt = '0;
                        w_blank_nxt    = 1'b0;
                        w_done_nxt     = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_mute_cnt_nxt = r_mute_cnt + MUTE_CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vid_mode_ctrl.sv
// Randomized scoreboard bench for vid_mode_ctrl: the driver plans vsync timing per request,
// predicts the response intervals, and a negedge monitor compares every cycle.
module tb_vid_mode_ctrl;

    localparam int T = 50;
    localparam int R = 4;
    localparam int M = 2;
    localparam int DEF_RES = 0;

    localparam int K_SW   = 0;
    localparam int K_SAME = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int kind;
        int old_res;
        int new_res;
        int t_acc;
        int t_rst;
        int t_done;
    } exp_t;

    logic       clk_pix;
    logic       rst_pix;
    logic       req_valid;
    logic [1:0] req_res;
    logic       req_ready;
    logic       vsync;
    logic [1:0] res_out;
    logic       tim_rst;
    logic       blank;
    logic       busy;
    logic       done;
    logic       err;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cur = DEF_RES;
    int   mon_res = DEF_RES;
    exp_t exp_q[$];

    vid_mode_ctrl #(
        .DEFAULT_RES (2'(DEF_RES)),
        .RST_CYCLES  (R),
        .MUTE_FRAMES (M),
        .VS_TIMEOUT  (T)
    ) dut (
        .clk_pix   (clk_pix),
        .rst_pix   (rst_pix),
        .req_valid (req_valid),
        .req_res   (req_res),
        .req_ready (req_ready),
        .vsync     (vsync),
        .res_out   (res_out),
        .tim_rst   (tim_rst),
        .blank     (blank),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk_pix = 1'b0;
        forever #5 clk_pix = ~clk_pix;
    end

    always @(posedge clk_pix) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input int expv);
        n_cmp++;
        if (act !== 32'(expv)) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, expv);
        end
    endtask

    // Spec-level prediction: switch at the first sync start within the timeout window
    // (else at the timeout), then done on the M-th sync start after the reset pulse ends.
    function automatic exp_t predict(input int r, input int cur_res, input int a, input int falls[$]);
        exp_t e;
        int   n;
        e.kind    = (r == 3) ? K_ERR : ((r == cur_res) ? K_SAME : K_SW);
        e.old_res = cur_res;
        e.new_res = cur_res;
        e.t_acc   = a;
        e.t_rst   = -1;
        e.t_done  = a;
        if (e.kind == K_SW) begin
            e.new_res = r;
            e.t_rst   = a + T;
            foreach (falls[i]) if (falls[i] > a && falls[i] < e.t_rst) e.t_rst = falls[i];
            n = 0;
            foreach (falls[i]) begin
                if (falls[i] > e.t_rst + R) begin
                    n++;
                    if (n == M) e.t_done = falls[i];
                end
            end
        end
        return e;
    endfunction

    // Requests presented while busy must be ignored; quiet down before returning to idle.
    task automatic noise(input int td);
        if (cyc < td - 1) begin
            req_valid = 1'($urandom_range(0, 1));
            req_res   = 2'($urandom_range(0, 3));
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic run_txn(input int r, input int d, input int bnd, input bit abort);
        int   a;
        int   dd;
        int   bb;
        int   lo;
        int   last;
        int   t_plan;
        int   n_exec;
        int   falls[$];
        exp_t e;

        repeat ($urandom_range(1, 3)) @(negedge clk_pix);
        for (int k = 0; k < 200 && req_ready !== 1'b1; k++) @(negedge clk_pix);
        if (req_ready !== 1'b1) begin
            chk("ready_wait", 32'(req_ready), 1);
            return;
        end

        a = cyc + 1;
        if (r != 3 && r != cur) begin
            dd = (d > 0) ? d : int'($urandom_range(1, T + 10));
            t_plan = a + T;
            if (dd <= T) begin
                falls.push_back(a + dd);
                t_plan = a + dd;
            end
            bb = (bnd >= 0) ? bnd : int'($urandom_range(0, 1));
            if (bb != 0) falls.push_back(t_plan + R);
            last = (falls.size() > 0) ? falls[$] : a;
            for (int k = 0; k < M; k++) begin
                lo   = (t_plan + R + 1 > last + 4) ? t_plan + R + 1 : last + 4;
                last = lo + int'($urandom_range(0, 20));
                falls.push_back(last);
            end
        end
        n_exec = (abort && falls.size() >= M) ? falls.size() - M + 1 : falls.size();

        e = predict(r, cur, a, falls);
        exp_q.push_back(e);
        cur = e.new_res;

        req_valid = 1'b1;
        req_res   = 2'(r);
        @(negedge clk_pix);
        req_valid = 1'b0;

        for (int i = 0; i < n_exec; i++) begin
            while (cyc < falls[i] - 1) begin
                @(negedge clk_pix);
                noise(e.t_done);
            end
            vsync = 1'b0;
            @(negedge clk_pix);
            noise(e.t_done);
            @(negedge clk_pix);
            noise(e.t_done);
            vsync = 1'b1;
        end

        if (abort) begin
            @(posedge clk_pix);
            #2;
            rst_pix   = 1'b1;
            req_valid = 1'b0;
            exp_q.delete();
            mon_res   = DEF_RES;
            cur       = DEF_RES;
            #1;
            chk("abort_res_out", 32'(res_out), DEF_RES);
            chk("abort_blank", 32'(blank), 0);
            chk("abort_busy", 32'(busy), 0);
            chk("abort_tim_rst", 32'(tim_rst), 0);
            chk("abort_done", 32'(done), 0);
            chk("abort_req_ready", 32'(req_ready), 1);
            @(posedge clk_pix);
            #2;
            rst_pix = 1'b0;
            @(negedge clk_pix);
        end else begin
            while (cyc < e.t_done + 1) begin
                @(negedge clk_pix);
                noise(e.t_done);
            end
            req_valid = 1'b0;
        end
    endtask

    always @(negedge clk_pix) begin : mon
        exp_t f;
        int   have;
        int   eb;
        int   et;
        int   ebl;
        int   er;
        int   ed;
        int   ee;
        if (!rst_pix) begin
            have = (exp_q.size() > 0) ? 1 : 0;
            if (have != 0) f = exp_q[0];
            eb = 0; et = 0; ebl = 0; ed = 0; ee = 0; er = mon_res;
            if (have != 0) begin
                er = f.old_res;
                if (f.kind == K_SW) begin
                    eb  = (cyc >= f.t_acc && cyc < f.t_done) ? 1 : 0;
                    et  = (cyc >= f.t_rst && cyc < f.t_rst + R) ? 1 : 0;
                    ebl = (cyc >= f.t_rst && cyc < f.t_done) ? 1 : 0;
                    if (cyc >= f.t_rst) er = f.new_res;
                end
                ed = (f.kind != K_ERR && cyc == f.t_done) ? 1 : 0;
                ee = (f.kind == K_ERR && cyc == f.t_done) ? 1 : 0;
            end
            chk("busy", 32'(busy), eb);
            chk("req_ready", 32'(req_ready), 1 - eb);
            chk("tim_rst", 32'(tim_rst), et);
            chk("blank", 32'(blank), ebl);
            chk("res_out", 32'(res_out), er);
            chk("done", 32'(done), ed);
            chk("err", 32'(err), ee);
            if (have != 0 && cyc >= f.t_done) begin
                void'(exp_q.pop_front());
                mon_res = f.new_res;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete at cyc %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_pix   = 1'b0;
        req_valid = 1'b0;
        req_res   = 2'd0;
        vsync     = 1'b1;

        #3;
        rst_pix = 1'b1;
        #1;
        chk("rst_res_out", 32'(res_out), DEF_RES);
        chk("rst_tim_rst", 32'(tim_rst), 0);
        chk("rst_blank", 32'(blank), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        repeat (3) @(posedge clk_pix);
        #2;
        rst_pix = 1'b0;
        @(negedge clk_pix);

        run_txn(1, 30, 0, 1'b0);
        run_txn(1, 0, -1, 1'b0);
        run_txn(3, 0, -1, 1'b0);
        run_txn(2, T + 5, 1, 1'b0);
        run_txn(2, 0, -1, 1'b0);
        run_txn(0, 1, 1, 1'b0);
        repeat (30) run_txn(int'($urandom_range(0, 3)), 0, -1, 1'b0);
        run_txn((cur + 1) % 3, 0, 0, 1'b1);
        run_txn(2, 0, -1, 1'b0);
        repeat (6) run_txn(int'($urandom_range(0, 3)), 0, -1, 1'b0);

        repeat (3) @(negedge clk_pix);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
